// File: rtl/cpld_uart_bridge.sv
// cpld_uart_bridge: CPLD-side host serial bridge.
// The host reads and writes single bytes over a shared 8-bit bus using the
// rdn/wrn strobes. The bridge does the asynchronous serial framing on txd/rxd
// and keeps one holding register in each direction.
// Default frame is 8N1 (10 bits). Define UART_PARITY_EN to insert an even
// parity bit after data bit 7 (11-bit frame); the receiver then discards
// bytes whose parity does not match.
// CLKS_PER_BIT must be >= 4.
//
// TX FSM
//   state    | meaning
//   T_IDLE   | line high, waiting for THR to fill
//   T_START  | start bit (txd=0)
//   T_DATA   | 8 data bits, LSB first
//   T_PARITY | even parity bit (UART_PARITY_EN only)
//   T_STOP   | stop bit (txd=1), then reload or go idle
//
// RX FSM
//   state    | meaning
//   R_IDLE   | waiting for a falling edge on synchronized rxd
//   R_START  | half-bit wait, confirm start bit is still low
//   R_DATA   | sample 8 data bits at bit centre, LSB first
//   R_PARITY | sample parity bit (UART_PARITY_EN only)
//   R_STOP   | sample stop bit, commit byte to RBR if valid

module cpld_uart_bridge #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rdn,
  input  logic       uart_wrn,
  inout  wire  [7:0] uart_data,
  output logic       uart_dataready,
  output logic       uart_tbre,
  output logic       uart_tsre,
  output logic       txd,
  input  logic       rxd
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  typedef enum logic [2:0] {
    T_IDLE,
    T_START,
    T_DATA,
`ifdef UART_PARITY_EN
    T_PARITY,
`endif
    T_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
`ifdef UART_PARITY_EN
    R_PARITY,
`endif
    R_STOP
  } rx_state_t;

  // host strobe sampling and edge detect
  logic wrn_q, rdn_q;
  logic wr_edge, rd_edge;

  // write path
  logic [7:0] stage;
  logic [7:0] thr;
  logic       thr_full;
  logic       tx_load;

  // transmitter
  tx_state_t     tx_state, tx_state_nxt;
  logic [BW-1:0] tx_baud, tx_baud_nxt;
  logic [2:0]    tx_bit, tx_bit_nxt;
  logic [7:0]    tx_shift, tx_shift_nxt;
  logic          txd_nxt;
  logic          tsre_nxt;
`ifdef UART_PARITY_EN
  logic          tx_par, tx_par_nxt;
`endif

  // receiver
  logic          rx_s1, rx_s2, rx_s3;
  rx_state_t     rx_state, rx_state_nxt;
  logic [BW-1:0] rx_baud, rx_baud_nxt;
  logic [2:0]    rx_bit, rx_bit_nxt;
  logic [7:0]    rx_shift, rx_shift_nxt;
  logic          rx_done;
  logic [7:0]    rbr;
`ifdef UART_PARITY_EN
  logic          rx_par_ok, rx_par_ok_nxt;
`endif

  assign wr_edge   = ~wrn_q & uart_wrn;
  assign rd_edge   = ~rdn_q & uart_rdn;
  assign uart_tbre = ~thr_full;

  // Bus is driven only for a clean read; both strobes low is treated as a conflict.
  assign uart_data = (~uart_rdn & uart_wrn) ? rbr : 8'bz;

  // Register the host strobes for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrn_q <= 1'b1;
      rdn_q <= 1'b1;
    end else begin
      wrn_q <= uart_wrn;
      rdn_q <= uart_rdn;
    end
  end

  // Capture bus data while wrn is low; commit to THR on the wrn rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage    <= 8'h00;
      thr      <= 8'h00;
      thr_full <= 1'b0;
    end else begin
      if (!uart_wrn) stage <= uart_data;
      if (wr_edge) begin
        thr      <= stage;
        thr_full <= 1'b1;
      end else if (tx_load) begin
        thr_full <= 1'b0;
      end
    end
  end

  // TX state register; txd is registered so the line never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= T_IDLE;
      tx_baud   <= '0;
      tx_bit    <= 3'd0;
      tx_shift  <= 8'h00;
      txd       <= 1'b1;
      uart_tsre <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par    <= 1'b0;
`endif
    end else begin
      tx_state  <= tx_state_nxt;
      tx_baud   <= tx_baud_nxt;
      tx_bit    <= tx_bit_nxt;
      tx_shift  <= tx_shift_nxt;
      txd       <= txd_nxt;
      uart_tsre <= tsre_nxt;
`ifdef UART_PARITY_EN
      tx_par    <= tx_par_nxt;
`endif
    end
  end

  // TX next-state: baud down-counter reloads on every state entry.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_baud_nxt  = tx_baud;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tsre_nxt     = uart_tsre;
    tx_load      = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_nxt   = tx_par;
`endif
    case (tx_state)
      T_IDLE: begin
        if (thr_full) begin
          tx_load      = 1'b1;
          tx_shift_nxt = thr;
          tsre_nxt     = 1'b0;
          tx_baud_nxt  = BAUD_MAX;
          tx_state_nxt = T_START;
`ifdef UART_PARITY_EN
          tx_par_nxt   = ^thr;
`endif
        end
      end
      T_START: begin
        if (tx_baud == '0) begin
          tx_baud_nxt  = BAUD_MAX;
          tx_bit_nxt   = 3'd0;
          tx_state_nxt = T_DATA;
        end else begin
          tx_baud_nxt = tx_baud - BAUD_ONE;
        end
      end
      T_DATA: begin
        if (tx_baud == '0) begin
          tx_baud_nxt  = BAUD_MAX;
          tx_shift_nxt = {1'b0, tx_shift[7:1]};
          tx_bit_nxt   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_state_nxt = T_PARITY;
`else
            tx_state_nxt = T_STOP;
`endif
          end
        end else begin
          tx_baud_nxt = tx_baud - BAUD_ONE;
        end
      end
`ifdef UART_PARITY_EN
      T_PARITY: begin
        if (tx_baud == '0) begin
          tx_baud_nxt  = BAUD_MAX;
          tx_state_nxt = T_STOP;
        end else begin
          tx_baud_nxt = tx_baud - BAUD_ONE;
        end
      end
`endif
      T_STOP: begin
        if (tx_baud == '0) begin
          if (thr_full) begin
            // back-to-back: straight into the next start bit, no idle gap
            tx_load      = 1'b1;
            tx_shift_nxt = thr;
            tx_baud_nxt  = BAUD_MAX;
            tx_state_nxt = T_START;
`ifdef UART_PARITY_EN
            tx_par_nxt   = ^thr;
`endif
          end else begin
            tsre_nxt     = 1'b1;
            tx_state_nxt = T_IDLE;
          end
        end else begin
          tx_baud_nxt = tx_baud - BAUD_ONE;
        end
      end
      default: tx_state_nxt = T_IDLE;
    endcase

    case (tx_state_nxt)
      T_START:  txd_nxt = 1'b0;
      T_DATA:   txd_nxt = tx_shift_nxt[0];
`ifdef UART_PARITY_EN
      T_PARITY: txd_nxt = tx_par_nxt;
`endif
      default:  txd_nxt = 1'b1;
    endcase
  end

  // Two-flop synchronizer plus one history flop for falling-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // RX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state  <= R_IDLE;
      rx_baud   <= '0;
      rx_bit    <= 3'd0;
      rx_shift  <= 8'h00;
`ifdef UART_PARITY_EN
      rx_par_ok <= 1'b0;
`endif
    end else begin
      rx_state  <= rx_state_nxt;
      rx_baud   <= rx_baud_nxt;
      rx_bit    <= rx_bit_nxt;
      rx_shift  <= rx_shift_nxt;
`ifdef UART_PARITY_EN
      rx_par_ok <= rx_par_ok_nxt;
`endif
    end
  end

  // RX next-state: half-bit wait aligns later samples to bit centre.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_baud_nxt  = rx_baud;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_done      = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_ok_nxt = rx_par_ok;
`endif
    case (rx_state)
      R_IDLE: begin
        if (rx_s3 && !rx_s2) begin
          rx_baud_nxt  = BAUD_HALF;
          rx_state_nxt = R_START;
        end
      end
      R_START: begin
        if (rx_baud == '0) begin
          if (rx_s2) begin
            rx_state_nxt = R_IDLE;
          end else begin
            rx_baud_nxt  = BAUD_MAX;
            rx_bit_nxt   = 3'd0;
            rx_state_nxt = R_DATA;
          end
        end else begin
          rx_baud_nxt = rx_baud - BAUD_ONE;
        end
      end
      R_DATA: begin
        if (rx_baud == '0) begin
          rx_baud_nxt  = BAUD_MAX;
          rx_shift_nxt = {rx_s2, rx_shift[7:1]};
          rx_bit_nxt   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_nxt = R_PARITY;
`else
            rx_state_nxt = R_STOP;
`endif
          end
        end else begin
          rx_baud_nxt = rx_baud - BAUD_ONE;
        end
      end
`ifdef UART_PARITY_EN
      R_PARITY: begin
        if (rx_baud == '0) begin
          rx_par_ok_nxt = (rx_s2 == ^rx_shift);
          rx_baud_nxt   = BAUD_MAX;
          rx_state_nxt  = R_STOP;
        end else begin
          rx_baud_nxt = rx_baud - BAUD_ONE;
        end
      end
`endif
      R_STOP: begin
        if (rx_baud == '0) begin
          rx_state_nxt = R_IDLE;
`ifdef UART_PARITY_EN
          rx_done      = rx_s2 & rx_par_ok;
`else
          rx_done      = rx_s2;
`endif
        end else begin
          rx_baud_nxt = rx_baud - BAUD_ONE;
        end
      end
      default: rx_state_nxt = R_IDLE;
    endcase
  end

  // Receive holding register; a completing byte beats a simultaneous read clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbr            <= 8'h00;
      uart_dataready <= 1'b0;
    end else begin
      if (rx_done) begin
        rbr            <= rx_shift;
        uart_dataready <= 1'b1;
      end else if (rd_edge) begin
        uart_dataready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpld_uart_bridge.sv
// Testbench for cpld_uart_bridge with CLKS_PER_BIT=4. Expected serial frames
// are built from the byte value by arithmetic; the RX side is tracked by a
// tiny model (last good byte, dataready flag). An undriven bus reads 8'hFF
// through pullups.

module tb_cpld_uart_bridge;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdn = 1'b1;
  logic wrn = 1'b1;
  logic rxd = 1'b1;
  logic tb_drv = 1'b0;
  logic [7:0] tb_byte = 8'h00;
  wire  [7:0] uart_data;
  logic dataready, tbre, tsre, txd;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_rbr = 8'h00;
  logic exp_dr = 1'b0;

  always #5 clk = ~clk;

  assign uart_data = tb_drv ? tb_byte : 8'bz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (uart_data[gi]);
  end

  cpld_uart_bridge #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .uart_rdn(rdn),
    .uart_wrn(wrn),
    .uart_data(uart_data),
    .uart_dataready(dataready),
    .uart_tbre(tbre),
    .uart_tsre(tsre),
    .txd(txd),
    .rxd(rxd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level of bit i of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int i, input logic stop_val);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (FRAME == 11 && i == 9) return ^b;
    return stop_val;
  endfunction

  task automatic write_strobe(input logic [7:0] b);
    tb_byte = b;
    tb_drv  = 1'b1;
    wrn     = 1'b0;
    tick();
    tick();
    wrn    = 1'b1;
    tb_drv = 1'b0;
  endtask

  // Called right after wrn rises. Checks latency, then every cycle of one or
  // two frames; with two=1 the second byte is written during the first frame.
  task automatic tx_frames(input logic [7:0] b0, input logic [7:0] b1, input bit two);
    int nf;
    int fc;
    logic exp_tbre;
    tick();
    check("tbre_after_write", {txd, tbre, tsre}, 3'b101);
    tick();
    check("tx_load", {txd, tbre, tsre}, 3'b010);
    nf = two ? 2 : 1;
    fc = FRAME * CPB;
    for (int c = 0; c < nf * fc; c++) begin
      exp_tbre = !(two && c >= 11 && c < fc);
      check("tx_frame", {txd, tsre, tbre},
            {frame_bit((c >= fc) ? b1 : b0, (c % fc) / CPB, 1'b1), 1'b0, exp_tbre});
      if (two && c == 8) begin
        tb_byte = b1;
        tb_drv  = 1'b1;
        wrn     = 1'b0;
      end
      if (two && c == 10) begin
        wrn    = 1'b1;
        tb_drv = 1'b0;
      end
      tick();
    end
    check("tx_done", {txd, tsre, tbre}, 3'b111);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_val);
    for (int i = 0; i < FRAME; i++) begin
      rxd = frame_bit(b, i, stop_val);
      if (i == FRAME - 1) check("rx_dr_midframe", dataready, exp_dr);
      repeat (CPB) tick();
    end
    rxd = 1'b1;
    if (stop_val) begin
      exp_rbr = b;
      exp_dr  = 1'b1;
    end
    repeat (2 * CPB) tick();
    check("rx_dataready", dataready, exp_dr);
  endtask

  task automatic host_read();
    rdn = 1'b0;
    tick();
    check("read_bus", uart_data, exp_rbr);
    check("read_dr_held", dataready, exp_dr);
    rdn = 1'b1;
    #1;
    check("read_release", uart_data, 8'hFF);
    tick();
    exp_dr = 1'b0;
    check("read_dr_clear", dataready, exp_dr);
  endtask

  initial begin
    logic [7:0] rb;
    repeat (3) tick();
    rst = 1'b0;

    // reset / idle
    for (int i = 0; i < 100; i++) begin
      check("idle_status", {txd, tbre, tsre, dataready}, 4'b1110);
      check("idle_bus", uart_data, 8'hFF);
      tick();
    end

    // single frames: directed then random
    write_strobe(8'hA5);
    tx_frames(8'hA5, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      rb = 8'($urandom);
      write_strobe(rb);
      tx_frames(rb, 8'h00, 1'b0);
    end

    // back-to-back frames
    write_strobe(8'h3C);
    tx_frames(8'h3C, 8'hC3, 1'b1);
    rb = 8'($urandom);
    write_strobe(rb);
    tx_frames(rb, ~rb, 1'b1);

    // receive and read
    rx_frame(8'h5A, 1'b1);
    host_read();
    for (int k = 0; k < 3; k++) begin
      rb = 8'($urandom_range(0, 254));
      rx_frame(rb, 1'b1);
      host_read();
    end

    // glitch, then framing error: nothing delivered, RBR kept
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (3 * CPB) tick();
    check("glitch_dr", dataready, 1'b0);
    rx_frame(8'($urandom), 1'b0);
    check("framing_dr", dataready, 1'b0);
    host_read();

    // overrun: second byte replaces first
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    check("overrun_dr", dataready, 1'b1);
    host_read();

    // both strobes low: bus must stay undriven
    rdn = 1'b0;
    wrn = 1'b0;
    tick();
    check("conflict_bus", uart_data, 8'hFF);
    rdn = 1'b1;
    wrn = 1'b1;
    tick();
    tick();
    check("mid_tx_start", {txd, tsre}, 2'b00);

    // reset in the middle of the start bit
    rst = 1'b1;
    #1;
    check("rst_mid_tx", {txd, tbre, tsre, dataready}, 4'b1110);
    tick();
    rst = 1'b0;
    exp_rbr = 8'h00;
    exp_dr  = 1'b0;
    repeat (2 * CPB) tick();
    check("post_rst_idle", {txd, tbre, tsre}, 3'b111);
    host_read();

    // recovery after reset
    rb = 8'($urandom);
    write_strobe(rb);
    tx_frames(rb, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpld_uart_bridge.md
Name: cpld_uart_bridge

Overview:
- CPLD-side end of the host serial interface: responds to the host's rdn/wrn strobes on the shared 8-bit data bus.
- Generates the dataready/tbre/tsre status lines and performs the actual asynchronous serial framing on txd/rxd.
- Single-byte holding registers per direction, so RTL and benches can run without the physical CPLD.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); must be >= 4.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- uart_rdn  input  1  host read strobe, active-low
- uart_wrn  input  1  host write strobe, active-low
- uart_data  inout  8  shared data bus; driven only during reads, else high-Z
- uart_dataready  output  1  received byte waiting in RBR
- uart_tbre  output  1  transmit holding register (THR) empty
- uart_tsre  output  1  transmit shifter idle, line quiet
- txd  output  1  serial out, idle high
- rxd  input  1  serial in, asynchronous

Behaviour:
- Reset: txd=1, uart_dataready=0, uart_tbre=1, uart_tsre=1, uart_data high-Z; THR, RBR and both FSMs cleared/idle. Reset mid-frame aborts the frame immediately; txd returns high.
- Strobes are sampled by registers (wrn_q, rdn_q); edges are detected as 0 in the previous cycle and 1 in the current cycle.
- Write path: while uart_wrn=0, capture uart_data into a staging byte every cycle. On the wrn rising edge: THR <= staging byte; tbre <= 0 on the next cycle. A write while tbre=0 overwrites THR (previous byte lost, no flag).
- TX FSM states:
  - T_IDLE: if THR full, load shifter, set tbre=1 and tsre=0, go to T_START.
  - T_START: txd=0 for CLKS_PER_BIT cycles.
  - T_DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - T_STOP: txd=1 for CLKS_PER_BIT cycles.
  - After T_STOP: if THR full, reload and go straight to T_START (tsre stays 0); otherwise tsre=1 and go to T_IDLE.
  - Latency: wrn rising edge to txd falling is 2 clk.
- RX path: rxd passes through a 2-flop synchronizer.
- RX FSM states:
  - R_IDLE: wait for synchronized rxd falling edge.
  - R_START: wait CLKS_PER_BIT/2 (integer) cycles; if rxd=1, treat as a glitch and return to R_IDLE.
  - R_DATA: sample every CLKS_PER_BIT at bit centre, 8 bits LSB first.
  - R_STOP: sample at centre. If 1, RBR <= shift byte and dataready=1. If 0, framing error: byte discarded, dataready unchanged.
  - Return to R_IDLE after the stop sample.
- Read path: uart_data is driven with RBR combinationally when uart_rdn=0 and uart_wrn=1; both strobes low means no drive (bus-conflict guard). On the rdn rising edge, dataready <= 0.
- Overrun: a new byte completing while dataready=1 overwrites RBR; dataready stays 1.
- A new byte completing in the same cycle as the rdn rising edge wins: RBR holds the new byte and dataready=1.
- TX and RX run fully independently; a simultaneous write and RX completion are both honoured.
- Bit counters are 3 bits (wrap at 7 ends the data phase). The baud counter is $clog2(CLKS_PER_BIT) bits, reset at every state entry.

Optional Feature:
- UART_PARITY_EN: when defined, TX inserts an even-parity bit (XOR of data) after bit 7, before stop. RX samples it at bit centre; on mismatch the byte is discarded like a framing error. Frame is 11 bits.
- Without the macro: 8N1, 10-bit frame, no parity logic synthesized.

Test Plan:
- Reset then idle (CLKS_PER_BIT=4): txd=1, tbre=1, tsre=1, dataready=0, uart_data high-Z for 100 cycles.
- Write 0xA5 (wrn low 2 cycles, then high) -> tbre 0 then 1 as the shifter loads, tsre=0. txd shows 0,1,0,1,0,0,1,0,1,1 at 4 cycles each. tsre=1 exactly after the stop bit.
- Back-to-back writes 0x3C then 0xC3 (second issued while tsre=0) -> two frames with no idle gap between the stop bit and the next start. tsre stays 0 until the second stop completes.
- rxd frame carrying 0x5A -> dataready=1 after the stop-centre sample. rdn low gives uart_data=0x5A. rdn rising edge -> dataready=0 and bus high-Z.
- rxd low pulse of 1 cycle (glitch), then a frame with stop bit 0 -> dataready stays 0 and RBR is unchanged.
- Overrun: receive 0x11 and then 0x22 without a read -> dataready=1 and a read returns 0x22. Assert rst mid-TX frame -> txd=1 within 1 cycle, tbre=1, tsre=1.
